// File: rtl/dsp_pkg.sv
// Shared types and widths for the DSP48A1 output stage.
package dsp_pkg;

    localparam int unsigned DSP_P_W   = 48;
    localparam int unsigned DSP_CNT_W = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/dsp_skid_cnt.sv
// Saturating stall counter: counts cycles with inc=1, sticks at all-ones, clears only on reset.
module dsp_skid_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dsp_out_skid.sv
// Two-entry skid buffer on the DSP48A1 P output; in_ready doubles as the pipeline CE.
// Optional saturating stall counter enabled by DSP_SKID_STALL_CNT_EN.
module dsp_out_skid
    import dsp_pkg::*;
#(
    parameter int unsigned WIDTH = DSP_P_W,
    parameter int unsigned CNT_W = DSP_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef DSP_SKID_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    skid_state_t      state;
    logic [WIDTH-1:0] skid_data;
    logic             accept_c;
    logic             deliver_c;

    assign accept_c  = in_valid & in_ready;
    assign deliver_c = out_valid & out_ready;

    // State, data registers and the registered handshake outputs move together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_data  <= '0;
            skid_data <= '0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept_c) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (accept_c && deliver_c) begin
                        out_data <= in_data;
                    end else if (accept_c) begin
                        skid_data <= in_data;
                        in_ready  <= 1'b0;
                        state     <= FULL;
                    end else if (deliver_c) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain side can move
                    if (deliver_c) begin
                        out_data <= skid_data;
                        in_ready <= 1'b1;
                        state    <= BUSY;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= EMPTY;
                end
            endcase
        end
    end

`ifdef DSP_SKID_STALL_CNT_EN
    dsp_skid_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_valid & ~out_ready),
        .cnt   (stall_cnt)
    );
`else
    logic [CNT_W-1:0] unused_stall_w;
    assign unused_stall_w = '0;
`endif

endmodule
